fetch_unit: RTL and testbench

//  Instruction-fetch stage. Owns the PC, issues single-outstanding requests to instruction memory, and drives

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_perf_ctr.sv | 22 ++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// The optional perf counters are enabled by defining FETCH_PERF_EN.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch-stage event counters: output loads and stall cycles.
// Instantiated by fetch_unit only when FETCH_PERF_EN is defined.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_i,
  input  logic        stall_i,
  output logic [31:0] fetched_o,
  output logic [31:0] stall_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_o <= '0;
      stall_o   <= '0;
    end else begin
      if (fetch_i) fetched_o <= fetched_o + 32'd1;
      if (stall_i) stall_o   <= stall_o + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, stall, redirect.
// FETCH_PERF_EN adds perf_fetched_o / perf_stall_o counter ports.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus_4_o,
  output logic        valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  import mips_pkg::*;

  fetch_state_t state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q;
  logic [31:0] buf_q;
  logic [31:0] load_data;
  logic [31:0] next_pc;
  logic [31:0] redir_pc;
  logic        kill_q, kill_d;
  logic        load;
  logic        buf_wr;

  assign redir_pc  = redirect_pc_i & ~32'd3;
  assign next_pc   = req_addr_q + PC_STEP;
  assign imem_req  = (state_q == REQ);
  assign imem_addr = req_addr_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    load      = 1'b0;
    buf_wr    = 1'b0;
    load_data = buf_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect_i) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (!stall_i) begin
            load      = 1'b1;
            load_data = imem_rdata;
            pc_d      = next_pc;
            state_d   = REQ;
          end else begin
            buf_wr  = 1'b1;
            pc_d    = next_pc;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_i) begin
          state_d = REQ;
        end else if (!stall_i) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A request already on the bus must still be answered; mark it stale.
    if (redirect_i) begin
      pc_d = redir_pc;
      if (state_q == REQ || (state_q == WAIT && !imem_rvalid))
        kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      buf_q      <= NOP_INSTR;
      kill_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      if (state_d == REQ && state_q != REQ)
        req_addr_q <= pc_d;
      if (buf_wr)
        buf_q <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_o     <= NOP_INSTR;
      pc_plus_4_o <= '0;
      valid_o     <= 1'b0;
    end else if (redirect_i) begin
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end else if (load) begin
      instr_o     <= load_data;
      pc_plus_4_o <= next_pc;
      valid_o     <= 1'b1;
    end else if (!stall_i) begin
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk       (clk),
    .reset     (reset),
    .fetch_i   (load),
    .stall_i   (stall_i),
    .fetched_o (perf_fetched_o),
    .stall_o   (perf_stall_o)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus latency,
// redirect, wrap-around and mid-transaction reset sequences.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic        N   = 1'b0;
  localparam logic        Y   = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_plus_4_o;
  logic        valid_o;

  logic        reset2;
  logic        req2;
  logic [31:0] addr2;
  logic        rv2;
  logic [31:0] rd2;
  logic [31:0] instr2;
  logic [31:0] pc42;
  logic        valid2;

`ifdef FETCH_PERF_EN
  logic [31:0] pf_fetch, pf_stall, pf_fetch2, pf_stall2;
`endif

  fetch_unit u_dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_o       (instr_o),
    .pc_plus_4_o   (pc_plus_4_o),
    .valid_o       (valid_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o(pf_fetch),
    .perf_stall_o  (pf_stall)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk           (clk),
    .reset         (reset2),
    .imem_req      (req2),
    .imem_addr     (addr2),
    .imem_gnt      (req2),
    .imem_rvalid   (rv2),
    .imem_rdata    (rd2),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .instr_o       (instr2),
    .pc_plus_4_o   (pc42),
    .valid_o       (valid2)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o(pf_fetch2),
    .perf_stall_o  (pf_stall2)
`endif
  );

  // Zero-wait memory for u_dut2, returns the address as data.
  always @(posedge clk or posedge reset2) begin
    if (reset2) begin
      rv2 <= 1'b0;
      rd2 <= 32'h0;
    end else begin
      rv2 <= req2;
      if (req2) rd2 <= addr2;
    end
  end

  // Main memory model: programmable grant and response delay.
  int unsigned gnt_dly, rv_dly;
  int unsigned wcnt, rcnt;
  logic        resp_act;
  logic [31:0] resp_data;

  assign imem_gnt    = imem_req && (wcnt >= gnt_dly);
  assign imem_rvalid = resp_act && (rcnt == 0);
  assign imem_rdata  = imem_rvalid ? resp_data : 32'hDEAD_BEEF;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt      <= 0;
      rcnt      <= 0;
      resp_act  <= 1'b0;
      resp_data <= 32'h0;
    end else begin
      if (imem_req && !imem_gnt) wcnt <= wcnt + 1;
      else                       wcnt <= 0;
      if (imem_gnt) begin
        resp_act  <= 1'b1;
        rcnt      <= rv_dly - 1;
        resp_data <= imem_addr;
      end else if (imem_rvalid) begin
        resp_act <= 1'b0;
      end else if (resp_act) begin
        rcnt <= rcnt - 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  task automatic tick();
    @(negedge clk);
    if (reset) begin
      prev_pend = 1'b0;
    end else begin
      if (imem_req) chk1("one_outstanding", resp_act, 1'b0);
      if (prev_pend) begin
        chk1("req_held", imem_req, 1'b1);
        chk32("addr_stable", imem_addr, prev_addr);
      end
      prev_pend = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end
  endtask

  task automatic do_reset(input int unsigned g, input int unsigned r);
    reset         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    gnt_dly       = g;
    rv_dly        = r;
    tick();
    tick();
    chk1("rst_valid", valid_o, 1'b0);
    chk32("rst_instr", instr_o, NOP);
    chk32("rst_pc4", pc_plus_4_o, 32'h0);
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, 32'h0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  function automatic vec_t mk(logic s, logic r, logic [31:0] rp,
                              logic ev, logic [31:0] ei,
                              logic [31:0] ep, logic eq,
                              logic [31:0] ea);
    mk = '{s, r, rp, ev, ei, ep, eq, ea};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vt[19];
  int   n;

  initial begin
    reset  = 1'b1;
    reset2 = 1'b1;

    // stall, redir, rpc | valid, instr, pc4, req, addr
    vt[0]  = mk(N, N, 32'h0,   N, NOP,          32'h0,   Y, 32'h0);
    vt[1]  = mk(N, N, 32'h0,   N, NOP,          32'h0,   N, 32'h0);
    vt[2]  = mk(N, N, 32'h0,   Y, 32'h0,        32'h4,   Y, 32'h4);
    vt[3]  = mk(N, N, 32'h0,   N, NOP,          32'h4,   N, 32'h0);
    vt[4]  = mk(N, N, 32'h0,   Y, 32'h4,        32'h8,   Y, 32'h8);
    vt[5]  = mk(N, N, 32'h0,   N, NOP,          32'h8,   N, 32'h0);
    vt[6]  = mk(N, N, 32'h0,   Y, 32'h8,        32'hC,   Y, 32'hC);
    vt[7]  = mk(Y, N, 32'h0,   Y, 32'h8,        32'hC,   N, 32'h0);
    vt[8]  = mk(Y, N, 32'h0,   Y, 32'h8,        32'hC,   N, 32'h0);
    vt[9]  = mk(Y, N, 32'h0,   Y, 32'h8,        32'hC,   N, 32'h0);
    vt[10] = mk(Y, N, 32'h0,   Y, 32'h8,        32'hC,   N, 32'h0);
    vt[11] = mk(Y, N, 32'h0,   Y, 32'h8,        32'hC,   N, 32'h0);
    vt[12] = mk(N, N, 32'h0,   Y, 32'hC,        32'h10,  Y, 32'h10);
    vt[13] = mk(N, N, 32'h0,   N, NOP,          32'h10,  N, 32'h0);
    vt[14] = mk(N, N, 32'h0,   Y, 32'h10,       32'h14,  Y, 32'h14);
    vt[15] = mk(N, N, 32'h0,   N, NOP,          32'h14,  N, 32'h0);
    vt[16] = mk(N, Y, 32'h403, N, NOP,          32'h14,  Y, 32'h400);
    vt[17] = mk(N, N, 32'h0,   N, NOP,          32'h14,  N, 32'h0);
    vt[18] = mk(N, N, 32'h0,   Y, 32'h400,      32'h404, Y, 32'h404);

    // Zero-wait stream, stall over a response, redirect with rvalid.
    do_reset(0, 1);
    for (int i = 0; i < 19; i++) begin
      stall_i       = vt[i].stall;
      redirect_i    = vt[i].redir;
      redirect_pc_i = vt[i].rpc;
      tick();
      chk1($sformatf("v%0d_valid", i), valid_o, vt[i].e_valid);
      chk32($sformatf("v%0d_instr", i), instr_o, vt[i].e_instr);
      chk32($sformatf("v%0d_pc4", i), pc_plus_4_o, vt[i].e_pc4);
      chk1($sformatf("v%0d_req", i), imem_req, vt[i].e_req);
      if (vt[i].e_req)
        chk32($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
    end
    stall_i    = 1'b0;
    redirect_i = 1'b0;

    // Grant after 3 cycles, response 2 cycles after grant.
    do_reset(3, 2);
    n = 0;
    while (!valid_o && n < 30) begin
      tick();
      n++;
    end
    chk32("slow_latency", 32'(n), 32'd7);
    chk32("slow_instr0", instr_o, 32'h0);
    chk32("slow_pc4_0", pc_plus_4_o, 32'h4);
    n = 0;
    while (valid_o && n < 5) begin
      tick();
      n++;
    end
    n = 0;
    while (!valid_o && n < 30) begin
      tick();
      n++;
    end
    chk32("slow_instr1", instr_o, 32'h4);
    chk32("slow_pc4_1", pc_plus_4_o, 32'h8);

    // Redirect while waiting on a response.
    do_reset(0, 3);
    n = 0;
    while (!(imem_req && imem_addr == 32'h4) && n < 30) begin
      tick();
      n++;
    end
    chk1("redir_find", imem_req && imem_addr == 32'h4, 1'b1);
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0400;
    tick();
    redirect_i = 1'b0;
    chk1("redir_valid", valid_o, 1'b0);
    chk32("redir_instr", instr_o, NOP);
    chk32("redir_pc4", pc_plus_4_o, 32'h4);
    n = 0;
    while (!imem_req && n < 20) begin
      chk1("redir_no_valid", valid_o, 1'b0);
      chk32("redir_no_stale", instr_o, NOP);
      tick();
      n++;
    end
    chk1("redir_req", imem_req, 1'b1);
    chk32("redir_addr", imem_addr, 32'h400);
    n = 0;
    while (!valid_o && n < 20) begin
      tick();
      n++;
    end
    chk32("redir_new_instr", instr_o, 32'h400);
    chk32("redir_new_pc4", pc_plus_4_o, 32'h404);

    // PC wrap from 0xFFFF_FFFC and reset in the middle of WAIT.
    reset2 = 1'b0;
    tick();
    chk32("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    tick();
    tick();
    chk1("wrap_valid", valid2, 1'b1);
    chk32("wrap_instr", instr2, 32'hFFFF_FFFC);
    chk32("wrap_pc4", pc42, 32'h0);
    chk1("wrap_req", req2, 1'b1);
    chk32("wrap_next_addr", addr2, 32'h0);
    tick();
    chk1("wait_no_req", req2, 1'b0);
    reset2 = 1'b1;
    #1;
    chk1("midrst_valid", valid2, 1'b0);
    chk32("midrst_instr", instr2, NOP);
    chk32("midrst_pc4", pc42, 32'h0);
    chk1("midrst_req", req2, 1'b0);
    chk32("midrst_addr", addr2, 32'h0);
    tick();
    reset2 = 1'b0;
    tick();
    chk32("rerun_addr", addr2, 32'hFFFF_FFFC);
    chk1("rerun_valid0", valid2, 1'b0);
    tick();
    tick();
    chk1("rerun_valid", valid2, 1'b1);
    chk32("rerun_instr", instr2, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
